// File: rtl/mul_result_accumulator_if.sv
// rtl/mul_result_accumulator_if.sv - control, product and result signals of the accumulator
interface mul_result_accumulator_if #(
    parameter int LEN_W = 8
);
    logic                      start;
    logic [LEN_W-1:0]          length;
    logic [1:0]                precision;
    logic                      mul_valid;
    logic [31:0]               mul_result;
    logic                      out_ready;
    logic                      busy;
    logic                      acc_valid;
    logic [2*(16+LEN_W)-1:0]   acc_out;
    logic                      err;

    modport master (
        output start, length, precision, mul_valid, mul_result, out_ready,
        input  busy, acc_valid, acc_out, err
    );

    modport slave (
        input  start, length, precision, mul_valid, mul_result, out_ready,
        output busy, acc_valid, acc_out, err
    );
endinterface

// File: rtl/mul_result_accumulator.sv
// rtl/mul_result_accumulator.sv - sums a counted run of multiplier products, split-lane or full width
module mul_result_accumulator #(
    parameter int LEN_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    mul_result_accumulator_if.slave bus
);
    localparam int LANE_W = 16 + LEN_W;
    localparam int ACC_W  = 2 * LANE_W;

    localparam logic [1:0] PREC_LANES = 2'b00;
    localparam logic [1:0] PREC_WIDE  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         prec_q, prec_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               err_q, err_d;

    logic               start_legal;
    logic               last_product;
    logic [LANE_W-1:0]  lane0_sum;
    logic [LANE_W-1:0]  lane1_sum;
    logic [ACC_W-1:0]   wide_sum;
    logic [ACC_W-1:0]   acc_sum;

    // Lanes are summed separately so a lane0 carry can never leak into lane1.
    assign lane0_sum = acc_q[LANE_W-1:0]     + {{LEN_W{1'b0}}, bus.mul_result[15:0]};
    assign lane1_sum = acc_q[ACC_W-1:LANE_W] + {{LEN_W{1'b0}}, bus.mul_result[31:16]};
    assign wide_sum  = acc_q + {{(ACC_W-32){1'b0}}, bus.mul_result};
    assign acc_sum   = (prec_q == PREC_WIDE) ? wide_sum : {lane1_sum, lane0_sum};

    assign start_legal  = (bus.precision == PREC_LANES) || (bus.precision == PREC_WIDE);
    assign last_product = (cnt_q == len_q - LEN_W'(1));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        prec_d  = prec_q;
        acc_d   = acc_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (start_legal) begin
                        len_d   = bus.length;
                        prec_d  = bus.precision;
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = (bus.length == '0) ? DONE : ACCUM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                // Final product lands in acc_q on the same edge that enters DONE.
                if (bus.mul_valid) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (last_product) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            prec_q  <= PREC_LANES;
            acc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            prec_q  <= prec_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.acc_valid = (state_q == DONE);
    assign bus.acc_out   = acc_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mul_result_accumulator.sv
// tb/tb_mul_result_accumulator.sv - randomized scoreboard bench for mul_result_accumulator
module tb_mul_result_accumulator;
    localparam int LEN_W  = 8;
    localparam int LANE_W = 16 + LEN_W;
    localparam int ACC_W  = 2 * LANE_W;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [ACC_W-1:0] exp_q[$];
    logic [31:0]      prods[$];
    bit               seen_valid;

    mul_result_accumulator_if #(.LEN_W(LEN_W)) bus ();

    mul_result_accumulator #(.LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result: plain arithmetic over the product list.
    function automatic logic [ACC_W-1:0] model(input logic [1:0] prec, input logic [31:0] p[$]);
        longint s0, s1, sw;
        logic [LANE_W-1:0] l0, l1;
        s0 = 0; s1 = 0; sw = 0;
        foreach (p[i]) begin
            s0 += longint'(p[i][15:0]);
            s1 += longint'(p[i][31:16]);
            sw += longint'(p[i]);
        end
        l0 = LANE_W'(s0);
        l1 = LANE_W'(s1);
        if (prec == 2'b11) return ACC_W'(sw);
        return {l1, l0};
    endfunction

    // Monitor: compares each newly presented result against the scoreboard head.
    always @(negedge clk) begin
        if (rst && bus.acc_valid && !seen_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got 0x%0h expected no result", bus.acc_out);
            end else begin
                check("sb_result", 64'(bus.acc_out), 64'(exp_q.pop_front()));
            end
        end
        seen_valid = bus.acc_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int len, input logic [1:0] prec, input int max_gap, input int hold);
        logic [ACC_W-1:0] exp;
        int g;
        while (prods.size() < len) prods.push_back($urandom);
        exp = model(prec, prods);
        exp_q.push_back(exp);
        bus.start = 1'b1; bus.length = LEN_W'(len); bus.precision = prec;
        tick();
        bus.start = 1'b0;
        bus.length = LEN_W'($urandom);
        bus.precision = 2'($urandom);
        if (len == 0) begin
            check("len0_valid", 64'(bus.acc_valid), 64'd1);
            check("len0_out", 64'(bus.acc_out), 64'd0);
        end else begin
            check("accum_busy", 64'({bus.busy, bus.acc_valid}), 64'b10);
        end
        for (int i = 0; i < len; i++) begin
            g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            repeat (g) begin
                bus.mul_valid = 1'b0; bus.mul_result = $urandom;
                tick();
            end
            bus.mul_valid = 1'b1; bus.mul_result = prods[i];
            tick();
            bus.mul_valid = 1'b0;
            if (i == len - 1) check("last_edge_valid", 64'(bus.acc_valid), 64'd1);
            else check("mid_valid_low", 64'(bus.acc_valid), 64'd0);
        end
        repeat (hold) begin
            bus.start = 1'($urandom); bus.mul_valid = 1'($urandom); bus.mul_result = $urandom;
            tick();
            check("hold_valid", 64'({bus.busy, bus.acc_valid}), 64'b11);
            check("hold_out", 64'(bus.acc_out), 64'(exp));
        end
        bus.mul_valid = 1'b0;
        bus.start = 1'b1; bus.precision = 2'b00; bus.length = 8'd1;
        bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0; bus.out_ready = 1'b0;
        check("handoff_idle", 64'({bus.busy, bus.acc_valid}), 64'b00);
        check("retain_out", 64'(bus.acc_out), 64'(exp));
        prods.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0; checks = 0; seen_valid = 1'b0;
        bus.start = 0; bus.length = 0; bus.precision = 0;
        bus.mul_valid = 0; bus.mul_result = 0; bus.out_ready = 0;
        rst = 1'b0;
        #12;
        check("reset_state", 64'({bus.busy, bus.acc_valid, bus.err}), 64'b000);
        check("reset_out", 64'(bus.acc_out), 64'd0);
        rst = 1'b1;
        tick();

        // Mode 00 directed: lanes 6 and 4 three times.
        repeat (3) prods.push_back(32'h0004_0006);
        run_op(3, 2'b00, 0, 0);
        // Mode 11 directed with gaps.
        repeat (2) prods.push_back(32'hFFFE_0001);
        run_op(2, 2'b11, 3, 1);
        run_op(0, 2'b00, 0, 2);
        // Backpressure with a random lane product.
        run_op(4, 2'b00, 1, 5);

        // Reserved precision codes.
        for (int k = 1; k <= 2; k++) begin
            bus.start = 1'b1; bus.precision = 2'(k); bus.length = 8'd3;
            tick();
            bus.start = 1'b0;
            check("err_pulse", 64'({bus.err, bus.busy}), 64'b10);
            tick();
            check("err_clear", 64'({bus.err, bus.busy}), 64'b00);
        end

        // Asynchronous reset after 2 of 4 products.
        bus.start = 1'b1; bus.precision = 2'b00; bus.length = 8'd4;
        tick();
        bus.start = 1'b0;
        repeat (2) begin
            bus.mul_valid = 1'b1; bus.mul_result = 32'h0101_0202;
            tick();
        end
        bus.mul_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_rst_state", 64'({bus.busy, bus.acc_valid}), 64'b00);
        check("async_rst_out", 64'(bus.acc_out), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op(2, 2'b11, 1, 1);

        // Maximum-length runs of maximum products.
        repeat (255) prods.push_back(32'hFFFE_0001);
        run_op(255, 2'b11, 0, 0);
        repeat (255) prods.push_back(32'hFE01_FE01);
        run_op(255, 2'b00, 0, 0);

        for (int n = 0; n < 20; n++) begin
            run_op($urandom_range(0, 6), ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00,
                   $urandom_range(0, 2), $urandom_range(0, 3));
        end

        tick();
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mul_result_accumulator.md
MUL_RESULT_ACCUMULATOR -- requirements
Module: mul_result_accumulator

Interface
REQ-001 The block SHALL have parameter LEN_W, default 8, meaning the width of the element-count field; lane accumulators are 16+LEN_W bits and the 16x16 accumulator is 32+LEN_W bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1, request to begin an accumulation; sampled in IDLE only.
REQ-005 The block SHALL have port length, input, LEN_W, number of products to accumulate; sampled with start.
REQ-006 The block SHALL have port precision, input, 2, lane mode; sampled with start; 2'b00 = two 8x8 lanes, 2'b11 = one 16x16 product, 2'b01/2'b10 reserved.
REQ-007 The block SHALL have port mul_valid, input, 1, qualifies mul_result this cycle.
REQ-008 The block SHALL have port mul_result, input, 32, registered output of multiplier_16bit; lane0 = [15:0], lane1 = [31:16] in mode 00.
REQ-009 The block SHALL have port out_ready, input, 1, downstream accepts acc_out.
REQ-010 The block SHALL have port busy, output, 1, high in ACCUM and DONE.
REQ-011 The block SHALL have port acc_valid, output, 1, acc_out holds a completed result.
REQ-012 The block SHALL have port acc_out, output, 2*(16+LEN_W), the result; mode 00: {lane1_sum, lane0_sum}, each 16+LEN_W bits; mode 11: zero-extended 32+LEN_W-bit sum.
REQ-013 The block SHALL have port err, output, 1, one-cycle pulse on a start with reserved precision.

Function
REQ-014 The block SHALL implement states IDLE, ACCUM, DONE, with IDLE after reset.
REQ-015 In IDLE, start=1 with precision 00 or 11 SHALL latch length and precision, clear the accumulators and element counter, and go to ACCUM; if length=0 it SHALL go directly to DONE with acc_out=0.
REQ-016 In IDLE, start=1 with precision 01 or 10 SHALL pulse err high for exactly the following cycle and remain in IDLE.
REQ-017 In ACCUM, each cycle with mul_valid=1 SHALL add the product(s) per the latched precision and increment the counter; mode 00 adds the two 16-bit lanes independently with no carry between lanes; mode 11 adds the full 32-bit value.
REQ-018 Cycles in ACCUM with mul_valid=0 SHALL leave accumulators and counter unchanged; there is no timeout.
REQ-019 On the edge that accepts product number length, the block SHALL register the final sum, assert acc_valid and enter DONE (zero added latency after the last product).
REQ-020 Accumulator widths SHALL guarantee no overflow for length up to 2^LEN_W-1 of maximum products (0xFE01 per lane, 0xFFFE0001 in mode 11).
REQ-021 In DONE, acc_out and acc_valid SHALL hold stable while out_ready=0; out_ready=1 SHALL return the block to IDLE with acc_valid low on the next cycle; acc_out retains its value until the next start.
REQ-022 mul_valid in IDLE or DONE SHALL be ignored; start in ACCUM or DONE SHALL be ignored, including in the same cycle as the DONE handoff.
REQ-023 Changes to precision or length after start is accepted SHALL not affect the operation in progress.

Reset
REQ-024 rst=0 SHALL immediately, without a clock, force IDLE, busy=0, acc_valid=0, err=0, acc_out=0, and clear counter and accumulators, including mid-ACCUM or in DONE.
REQ-025 After rst returns high, the block SHALL accept start on the first rising edge.

Verification
REQ-026 The bench SHALL cover reset: pulse rst low mid-ACCUM after 2 of 4 products -> busy=0, acc_valid=0 and acc_out=0 asynchronously, and a fresh start succeeds.
REQ-027 The bench SHALL cover mode 00: length=3 with mul_result=0x0004_0006 on three consecutive cycles -> acc_valid on the third accept edge, lane0_sum=18, lane1_sum=12.
REQ-028 The bench SHALL cover mode 11: length=2 with mul_result=0xFFFE_0001 twice and gaps of mul_valid=0 between them -> acc_out=0x1_FFFC_0002.
REQ-029 The bench SHALL cover length 0: start with length=0 -> acc_valid=1 the next cycle with acc_out=0.
REQ-030 The bench SHALL cover backpressure: out_ready=0 for 5 cycles in DONE while mul_valid and start toggle -> acc_out is unchanged and the state is DONE; out_ready=1 -> IDLE next cycle.
REQ-031 The bench SHALL cover reserved precision: start with precision=2'b01 -> err high for one cycle, busy stays 0.
